// File: rtl/decode_hazard_controller_pkg.sv
// HighLevelControl: shared types for the Decode hazard controller.
// Holds opcodes, immediate/forward selects, scoreboard entry and match helpers.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BIT_COUNT
`define BIT_COUNT 5
`endif

package HighLevelControl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_R32    = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IType = 3'd0,
        SType = 3'd1,
        BType = 3'd2,
        UType = 3'd3,
        JType = 3'd4,
        Shamt = 3'd5
    } immSrc;

    typedef enum logic [1:0] {
        FwdRF = 2'b00,
        FwdW  = 2'b01,
        FwdM  = 2'b10
    } fwdSrc;

    typedef struct packed {
        logic                  valid;
        logic [`BIT_COUNT-1:0] rd;
        logic                  isLoad;
    } scoreEntry;

    // x0 is hardwired, so it never produces a match
    function automatic logic entry_hits(
        input scoreEntry             e,
        input logic [`BIT_COUNT-1:0] r
    );
        return e.valid && (r != '0) && (e.rd == r);
    endfunction

    function automatic logic src_hit(
        input scoreEntry             e,
        input logic                  u1,
        input logic [`BIT_COUNT-1:0] r1,
        input logic                  u2,
        input logic [`BIT_COUNT-1:0] r2
    );
        return (u1 && entry_hits(e, r1)) || (u2 && entry_hits(e, r2));
    endfunction

endpackage

// File: rtl/decode_hazard_controller_usage.sv
// instr_usage_decoder: maps a Decode instruction to its immediate select
// and register usage (uses rs1/rs2, writes rd, is load, register indices).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BIT_COUNT
`define BIT_COUNT 5
`endif

module instr_usage_decoder
    import HighLevelControl::*;
(
    input  logic [`WORD_SIZE-1:0] instr,
    output immSrc                 imm_src,
    output logic                  uses_rs1,
    output logic                  uses_rs2,
    output logic                  writes_rd,
    output logic                  is_load,
    output logic [`BIT_COUNT-1:0] rs1,
    output logic [`BIT_COUNT-1:0] rs2,
    output logic [`BIT_COUNT-1:0] rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign rd          = instr[7 +: `BIT_COUNT];
    assign rs1         = instr[15 +: `BIT_COUNT];
    assign rs2         = instr[20 +: `BIT_COUNT];
    assign unused_bits = ^instr[`WORD_SIZE-1:25];

    always_comb begin
        imm_src   = immSrc'(3'bxxx);
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        unique case (1'b1)
            (opcode == OP_R) || (opcode == OP_R32): begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            (opcode == OP_IMM) || (opcode == OP_IMM32): begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                // shifts carry a shift amount, not a sign-extended imm
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    imm_src = Shamt;
                else
                    imm_src = IType;
            end
            (opcode == OP_LOAD): begin
                imm_src   = IType;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            (opcode == OP_JALR): begin
                imm_src   = IType;
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            (opcode == OP_STORE): begin
                imm_src  = SType;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                imm_src  = BType;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opcode == OP_LUI) || (opcode == OP_AUIPC): begin
                imm_src   = UType;
                writes_rd = 1'b1;
            end
            (opcode == OP_JAL): begin
                imm_src   = JType;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_hazard_controller.sv
// decode_hazard_controller: E/M/W destination scoreboard driving ImmSrcD,
// StallF/StallD, FlushD/FlushE, ForwardAE/BE and StallCount.
// Build option HAZARD_FORWARD_EN: load-use-only stalls plus forward selects;
// when undefined, full RAW stalls and ForwardAE/BE tied to 2'b00.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BIT_COUNT
`define BIT_COUNT 5
`endif

module decode_hazard_controller
    import HighLevelControl::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstrValidD,
    input  logic [`WORD_SIZE-1:0] InstrD,
    input  logic                  BranchTakenE,
    output immSrc                 ImmSrcD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [31:0]           StallCount
);

    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  writes_rd;
    logic                  is_load;
    logic [`BIT_COUNT-1:0] rs1;
    logic [`BIT_COUNT-1:0] rs2;
    logic [`BIT_COUNT-1:0] rd;

    scoreEntry sb_e;
    scoreEntry sb_m;
    scoreEntry sb_w;
    scoreEntry d_entry;

    logic raw_hazard;
    logic hazard;
    logic stall;
    logic issue;
    logic unused_w;

    instr_usage_decoder u_dec (
        .instr     (InstrD),
        .imm_src   (ImmSrcD),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd)
    );

`ifdef HAZARD_FORWARD_EN
    // only a load still in E cannot be bypassed in time
    assign raw_hazard = sb_e.isLoad &&
                        src_hit(sb_e, uses_rs1, rs1, uses_rs2, rs2);
`else
    // register file has no same-cycle bypass, so W also blocks
    assign raw_hazard = src_hit(sb_e, uses_rs1, rs1, uses_rs2, rs2) ||
                        src_hit(sb_m, uses_rs1, rs1, uses_rs2, rs2) ||
                        src_hit(sb_w, uses_rs1, rs1, uses_rs2, rs2);
`endif

    assign hazard = InstrValidD && raw_hazard;
    assign stall  = hazard && !BranchTakenE && !reset;
    assign issue  = InstrValidD && !hazard && !BranchTakenE && !reset;

    assign StallF = stall;
    assign StallD = stall;
    // wrong-path Decode instruction is discarded, which beats any stall
    assign FlushD = reset || BranchTakenE;
    assign FlushE = !issue;

    assign d_entry.valid  = writes_rd && (rd != '0);
    assign d_entry.rd     = rd;
    assign d_entry.isLoad = is_load;

    assign unused_w = sb_w.isLoad;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_e       <= '0;
            sb_m       <= '0;
            sb_w       <= '0;
            StallCount <= '0;
        end else begin
            sb_e <= issue ? d_entry : '0;
            sb_m <= sb_e;
            sb_w <= sb_m;
            if (stall && (StallCount != 32'hFFFF_FFFF))
                StallCount <= StallCount + 32'd1;
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic [`BIT_COUNT-1:0] rs1_e;
    logic [`BIT_COUNT-1:0] rs2_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e <= '0;
            rs2_e <= '0;
        end else begin
            rs1_e <= (issue && uses_rs1) ? rs1 : '0;
            rs2_e <= (issue && uses_rs2) ? rs2 : '0;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [`BIT_COUNT-1:0] r,
        input scoreEntry             m,
        input scoreEntry             w
    );
        if (entry_hits(m, r))
            return FwdM;
        else if (entry_hits(w, r))
            return FwdW;
        else
            return FwdRF;
    endfunction

    always_comb begin
        ForwardAE = FwdRF;
        ForwardBE = FwdRF;
        if (!reset) begin
            ForwardAE = fwd_sel(rs1_e, sb_m, sb_w);
            ForwardBE = fwd_sel(rs2_e, sb_m, sb_w);
        end
    end
`else
    assign ForwardAE = FwdRF;
    assign ForwardBE = FwdRF;
`endif

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Self-checking bench for decode_hazard_controller: ImmSrc table,
// directed hazard/flush/reset sequences, and a randomized model run.
`timescale 1ns/1ps
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BIT_COUNT
`define BIT_COUNT 5
`endif

module tb_decode_hazard_controller;
    import HighLevelControl::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int LU_PEN  = FWD ? 1 : 3;
    localparam int LU_FWD  = FWD ? 1 : 0;
    localparam int RAW_PEN = FWD ? 0 : 3;
    localparam int RAW_FWD = FWD ? 2 : 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrValidD;
    logic [31:0] InstrD;
    logic        BranchTakenE;
    immSrc       ImmSrcD;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCount;

    always #5 clk = ~clk;

    decode_hazard_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrValidD  (InstrValidD),
        .InstrD       (InstrD),
        .BranchTakenE (BranchTakenE),
        .ImmSrcD      (ImmSrcD),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallCount   (StallCount)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: list of in-flight writers, youngest (E) first
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    ent_t    pipe[$];
    int      m_src1, m_src2;
    longint  m_count;
    bit      known;

    logic       cap_stall, cap_flushd, cap_flushe;
    logic [1:0] cap_fwda, cap_fwdb;
    logic [31:0] cap_count;

    function automatic void ref_decode(input logic [31:0] ins,
        output bit u1, output bit u2, output bit wr, output bit ld,
        output int imm);
        u1 = 0; u2 = 0; wr = 0; ld = 0; imm = -1;
        case (ins[6:0])
            7'b0110011, 7'b0111011: begin u1 = 1; u2 = 1; wr = 1; end
            7'b0010011, 7'b0011011: begin
                u1 = 1; wr = 1;
                imm = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 5 : 0;
            end
            7'b0000011: begin u1 = 1; wr = 1; ld = 1; imm = 0; end
            7'b1100111: begin u1 = 1; wr = 1; imm = 0; end
            7'b0100011: begin u1 = 1; u2 = 1; imm = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; imm = 2; end
            7'b0110111, 7'b0010111: begin wr = 1; imm = 3; end
            7'b1101111: begin wr = 1; imm = 4; end
            default: ;
        endcase
    endfunction

    function automatic int exp_fwd(input int src);
        if (src == 0) return 0;
        if (pipe[1].v && pipe[1].rd == src) return 2;
        if (pipe[2].v && pipe[2].rd == src) return 1;
        return 0;
    endfunction

    task automatic clear_model();
        ent_t z;
        z = '{v: 1'b0, rd: 0, ld: 1'b0};
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(z);
        m_src1 = 0;
        m_src2 = 0;
        m_count = 0;
    endtask

    task automatic step(input bit v, input logic [31:0] ins,
                        input bit br, input bit rst);
        bit u1, u2, wr, ld, haz, st, iss;
        int imm, r1, r2, rd;
        ent_t ne;
        InstrValidD  = v;
        InstrD       = ins;
        BranchTakenE = br;
        reset        = rst;
        ref_decode(ins, u1, u2, wr, ld, imm);
        r1 = int'(ins[19:15]);
        r2 = int'(ins[24:20]);
        rd = int'(ins[11:7]);
        haz = 0;
        if (v) begin
            for (int i = 0; i < 3; i++) begin
                if (pipe[i].v && (!FWD || (i == 0 && pipe[i].ld))) begin
                    if ((u1 && r1 != 0 && r1 == pipe[i].rd) ||
                        (u2 && r2 != 0 && r2 == pipe[i].rd))
                        haz = 1;
                end
            end
        end
        st  = haz && !br && !rst;
        iss = v && !haz && !br && !rst;
        @(negedge clk);
        cap_stall  = StallF;
        cap_flushd = FlushD;
        cap_flushe = FlushE;
        cap_fwda   = ForwardAE;
        cap_fwdb   = ForwardBE;
        cap_count  = StallCount;
        chk("StallF", 32'(StallF), 32'(st));
        chk("StallD", 32'(StallD), 32'(st));
        chk("FlushD", 32'(FlushD), 32'(rst || br));
        chk("FlushE", 32'(FlushE), 32'(!iss));
        if (imm >= 0) chk("ImmSrcD", 32'(ImmSrcD), 32'(imm));
        chk("ForwardAE", 32'(ForwardAE),
            32'((FWD && !rst) ? exp_fwd(m_src1) : 0));
        chk("ForwardBE", 32'(ForwardBE),
            32'((FWD && !rst) ? exp_fwd(m_src2) : 0));
        if (known) chk("StallCount", StallCount, 32'(m_count));
        @(posedge clk);
        #1;
        if (rst) begin
            clear_model();
            known = 1;
        end else begin
            ne = '{v: iss && wr && rd != 0, rd: rd, ld: ld};
            pipe.push_front(ne);
            void'(pipe.pop_back());
            m_src1 = (iss && u1) ? r1 : 0;
            m_src2 = (iss && u2) ? r2 : 0;
            if (st && m_count != 64'hFFFF_FFFF) m_count++;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op,
        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h001, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_sb(input logic [6:0] op,
        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op,
        input logic [4:0] rd);
        return {20'h12345, rd, op};
    endfunction

    typedef struct {
        logic [31:0] ins;
        immSrc       exp;
    } imm_vec_t;

    imm_vec_t ivec[11];
    int       n;
    logic [31:0] NOP;
    logic [6:0]  ops[12];

    initial begin
        NOP = 32'h0000_0013;
        known = 0;
        clear_model();

        ivec[0]  = '{enc_i(7'b0010011, 3'b001, 5'd1, 5'd2), Shamt};
        ivec[1]  = '{enc_sb(7'b0100011, 5'd1, 5'd2), SType};
        ivec[2]  = '{enc_sb(7'b1100011, 5'd1, 5'd2), BType};
        ivec[3]  = '{enc_u(7'b0110111, 5'd3), UType};
        ivec[4]  = '{enc_u(7'b1101111, 5'd1), JType};
        ivec[5]  = '{enc_i(7'b1100111, 3'b000, 5'd1, 5'd2), IType};
        ivec[6]  = '{enc_i(7'b0010011, 3'b101, 5'd1, 5'd2), Shamt};
        ivec[7]  = '{enc_i(7'b0010011, 3'b000, 5'd1, 5'd2), IType};
        ivec[8]  = '{enc_i(7'b0000011, 3'b010, 5'd1, 5'd2), IType};
        ivec[9]  = '{enc_u(7'b0010111, 5'd4), UType};
        ivec[10] = '{enc_i(7'b0011011, 3'b001, 5'd1, 5'd2), Shamt};

        step(0, NOP, 0, 1);
        for (int i = 0; i < 11; i++) begin
            step(1, ivec[i].ins, 0, 0);
            chk($sformatf("imm_vec%0d", i), 32'(ImmSrcD), 32'(ivec[i].exp));
        end

        // load-use: lw x5,0(x1) then add x6,x5,x2
        step(0, NOP, 0, 1);
        step(1, enc_i(7'b0000011, 3'b010, 5'd5, 5'd1), 0, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, enc_r(5'd6, 5'd5, 5'd2), 0, 0);
            if (!cap_stall) break;
            n++;
        end
        chk("lu_penalty", 32'(n), 32'(LU_PEN));
        step(0, NOP, 0, 0);
        chk("lu_fwdA", 32'(cap_fwda), 32'(LU_FWD));
        chk("lu_count", cap_count, 32'(LU_PEN));

        // RAW on ALU result: addi x5,x0,1 then add x6,x5,x5
        step(0, NOP, 0, 1);
        step(1, enc_i(7'b0010011, 3'b000, 5'd5, 5'd0), 0, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, enc_r(5'd6, 5'd5, 5'd5), 0, 0);
            if (!cap_stall) break;
            n++;
        end
        chk("raw_penalty", 32'(n), 32'(RAW_PEN));
        step(0, NOP, 0, 0);
        chk("raw_fwdA", 32'(cap_fwda), 32'(RAW_FWD));
        chk("raw_fwdB", 32'(cap_fwdb), 32'(RAW_FWD));
        chk("raw_count", cap_count, 32'(RAW_PEN));

        // branch in the same cycle as a load-use hazard
        step(0, NOP, 0, 1);
        step(1, enc_i(7'b0000011, 3'b010, 5'd5, 5'd1), 0, 0);
        step(1, enc_r(5'd6, 5'd5, 5'd2), 1, 0);
        chk("br_flushD", 32'(cap_flushd), 32'd1);
        chk("br_flushE", 32'(cap_flushe), 32'd1);
        chk("br_stall", 32'(cap_stall), 32'd0);
        step(0, NOP, 0, 0);
        chk("br_count", cap_count, 32'd0);

        // x0 destination and sources never hazard
        step(0, NOP, 0, 1);
        step(1, enc_i(7'b0000011, 3'b010, 5'd0, 5'd1), 0, 0);
        step(1, enc_r(5'd6, 5'd0, 5'd0), 0, 0);
        chk("x0_stall", 32'(cap_stall), 32'd0);
        step(0, NOP, 0, 0);
        chk("x0_fwdA", 32'(cap_fwda), 32'd0);
        chk("x0_fwdB", 32'(cap_fwdb), 32'd0);

        // reset arriving while a stall is active
        step(0, NOP, 0, 1);
        step(1, enc_i(7'b0000011, 3'b010, 5'd5, 5'd1), 0, 0);
        step(1, enc_r(5'd6, 5'd5, 5'd5), 0, 0);
        chk("rs_pre_stall", 32'(cap_stall), 32'd1);
        step(1, enc_r(5'd6, 5'd5, 5'd5), 0, 1);
        chk("rs_stall", 32'(cap_stall), 32'd0);
        chk("rs_flushD", 32'(cap_flushd), 32'd1);
        chk("rs_flushE", 32'(cap_flushe), 32'd1);
        step(1, enc_r(5'd7, 5'd1, 5'd2), 0, 0);
        chk("rs_issue", 32'(cap_stall), 32'd0);
        step(0, NOP, 0, 0);
        chk("rs_count", cap_count, 32'd0);

        // randomized run against the model
        ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins;
            bit v, br, rst;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            v   = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 59) == 0);
            step(v, ins, br, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
